// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic array edge feeders.
package systolic_pkg;

    localparam int DEFAULT_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } feeder_state_e;

    // Number of skewed output steps needed to drain a LANES x DEPTH tile.
    function automatic int stream_len(input int lanes, input int depth);
        return depth + lanes - 1;
    endfunction

endpackage

// File: rtl/feeder_lane_buffer.sv
// One lane of the edge feeder: DEPTH operand registers with a skewed,
// zero-padded registered read driven by the shared step counter.
module feeder_lane_buffer
    import systolic_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int DEPTH    = 4,
    parameter int LANE_IDX = 0,
    parameter int STEP_W   = 3,
    parameter int ADDR_W   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [STEP_W-1:0] step,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid
);

    localparam logic [STEP_W:0] LANE_OFF = (STEP_W + 1)'(LANE_IDX);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [STEP_W:0]   rel_s;
    logic              hit_s;
    logic [DATA_W-1:0] sel_s;

    // Operand storage; writes are already gated to IDLE and in-range by the top.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_r[k] <= '0;
            end
        end else if (wr_en) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (wr_addr == ADDR_W'(k)) begin
                    mem_r[k] <= wr_data;
                end
            end
        end
    end

    // Skewed element select; a negative step-offset wraps high and never matches.
    always_comb begin
        rel_s = {1'b0, step} - LANE_OFF;
        hit_s = 1'b0;
        sel_s = '0;
        for (int k = 0; k < DEPTH; k++) begin
            hit_s = hit_s | (rel_s == (STEP_W + 1)'(k));
            sel_s = sel_s | (mem_r[k] & {DATA_W{rel_s == (STEP_W + 1)'(k)}});
        end
    end

    // Registered lane output; padding (and anything outside STREAM) reads as zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else if (rd_en) begin
            rd_data  <= sel_s;
            rd_valid <= hit_s;
        end else begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/systolic_edge_feeder.sv
// Edge feeder for a systolic multiply array: buffers a LANES x DEPTH tile and
// streams it out with lane i delayed i cycles and zero padding elsewhere.
module systolic_edge_feeder
    import systolic_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int LANES  = 4,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [$clog2(LANES)-1:0]   wr_lane,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic [LANES*DATA_W-1:0]    lane_out,
    output logic [LANES-1:0]           lane_valid
);

    localparam int S      = stream_len(LANES, DEPTH);
    localparam int STEP_W = $clog2(S + 1);
    localparam int LANE_W = $clog2(LANES);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(S - 1);

    feeder_state_e     state_r;
    feeder_state_e     next_state_s;
    logic [STEP_W-1:0] step_r;
    logic              busy_next_s;
    logic              done_next_s;
    logic              wr_ok_s;
    logic              rd_en_s;
    logic [LANES-1:0]  lane_we_s;

    // Writes land only while IDLE and with both indices inside the tile.
    assign wr_ok_s = wr_en && (state_r == IDLE)
                  && ({1'b0, wr_lane} < (LANE_W + 1)'(LANES))
                  && ({1'b0, wr_addr} < (ADDR_W + 1)'(DEPTH));
    assign rd_en_s = (state_r == STREAM);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; start is only honoured in IDLE.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    next_state_s = STREAM;
                end else begin
                    next_state_s = IDLE;
                end
            end
            STREAM: begin
                if (step_r == LAST_STEP) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = STREAM;
                end
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Output decode for the registered status flags.
    always_comb begin
        busy_next_s = 1'b0;
        done_next_s = 1'b0;
        case (next_state_s)
            IDLE: begin
                busy_next_s = 1'b0;
                done_next_s = 1'b0;
            end
            STREAM: begin
                busy_next_s = 1'b1;
                done_next_s = 1'b0;
            end
            DONE: begin
                busy_next_s = 1'b1;
                done_next_s = 1'b1;
            end
            default: begin
                busy_next_s = 1'b0;
                done_next_s = 1'b0;
            end
        endcase
    end

    // Registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= busy_next_s;
            done <= done_next_s;
        end
    end

    // Step counter: runs only in STREAM, held at zero otherwise so it never wraps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_r <= '0;
        end else if (state_r == STREAM) begin
            step_r <= step_r + STEP_W'(1);
        end else begin
            step_r <= '0;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign lane_we_s[i] = wr_ok_s && (wr_lane == LANE_W'(i));

        feeder_lane_buffer #(
            .DATA_W   (DATA_W),
            .DEPTH    (DEPTH),
            .LANE_IDX (i),
            .STEP_W   (STEP_W),
            .ADDR_W   (ADDR_W)
        ) u_buf (
            .clk      (clk),
            .reset    (reset),
            .wr_en    (lane_we_s[i]),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data),
            .rd_en    (rd_en_s),
            .step     (step_r),
            .rd_data  (lane_out[i*DATA_W +: DATA_W]),
            .rd_valid (lane_valid[i])
        );
    end

endmodule

// File: tb/tb_systolic_edge_feeder.sv
// Directed bench for systolic_edge_feeder: vector table plus hand sequences
// for reset abort, write/start collision and a small identity-matrix array.
module tb_systolic_edge_feeder;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en, start;
    logic [1:0]  wr_lane, wr_addr;
    logic [15:0] wr_data;
    logic        busy, done;
    logic [63:0] lane_out;
    logic [3:0]  lane_valid;

    logic        fa_wr_en, fb_wr_en, pe_start, pe_clr;
    logic [1:0]  f_lane, f_addr;
    logic [15:0] fa_data, fb_data;
    logic        fa_busy, fb_busy, fa_done, fb_done;
    logic [63:0] fa_out, fb_out;
    logic [3:0]  fa_valid, fb_valid;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        start;
        logic        wr_en;
        logic [1:0]  wr_lane;
        logic [1:0]  wr_addr;
        logic [15:0] wr_data;
        logic        exp_busy;
        logic        exp_done;
        logic [3:0]  exp_valid;
        logic [63:0] exp_out;
    } vec_t;

    vec_t        vecs[$];
    logic [15:0] mdl [4][4];
    logic [15:0] pa [4][4];
    logic [15:0] pb [4][4];
    logic [31:0] acc [4][4];
    logic [15:0] bmat [4][4];

    always #5 clk = ~clk;

    systolic_edge_feeder #(.DATA_W(16), .LANES(4), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_lane(wr_lane), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .busy(busy), .done(done),
        .lane_out(lane_out), .lane_valid(lane_valid)
    );

    systolic_edge_feeder #(.DATA_W(16), .LANES(4), .DEPTH(4)) u_fa (
        .clk(clk), .reset(reset), .wr_en(fa_wr_en), .wr_lane(f_lane), .wr_addr(f_addr),
        .wr_data(fa_data), .start(pe_start), .busy(fa_busy), .done(fa_done),
        .lane_out(fa_out), .lane_valid(fa_valid)
    );

    systolic_edge_feeder #(.DATA_W(16), .LANES(4), .DEPTH(4)) u_fb (
        .clk(clk), .reset(reset), .wr_en(fb_wr_en), .wr_lane(f_lane), .wr_addr(f_addr),
        .wr_data(fb_data), .start(pe_start), .busy(fb_busy), .done(fb_done),
        .lane_out(fb_out), .lane_valid(fb_valid)
    );

    function automatic logic [15:0] pe_a_in(input int i, input int j);
        if (j == 0) return fa_out[i*16 +: 16];
        else        return pa[i][j-1];
    endfunction

    function automatic logic [15:0] pe_b_in(input int i, input int j);
        if (i == 0) return fb_out[j*16 +: 16];
        else        return pb[i-1][j];
    endfunction

    // Output-stationary 4x4 PE array: A moves right, B moves down.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                pa[i][j]  <= pe_a_in(i, j);
                pb[i][j]  <= pe_b_in(i, j);
                acc[i][j] <= pe_clr ? 32'd0
                           : acc[i][j] + 32'(pe_a_in(i, j)) * 32'(pe_b_in(i, j));
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model_out(input int t);
        logic [63:0] r = '0;
        for (int i = 0; i < 4; i++) begin
            if (t - i >= 0 && t - i < 4) r[i*16 +: 16] = mdl[i][t-i];
        end
        return r;
    endfunction

    function automatic logic [3:0] model_valid(input int t);
        logic [3:0] r = '0;
        for (int i = 0; i < 4; i++) begin
            r[i] = (t - i >= 0) && (t - i < 4);
        end
        return r;
    endfunction

    task automatic push_row(input logic st, input logic we, input logic [1:0] ln,
                            input logic [1:0] ad, input logic [15:0] dt, input logic eb,
                            input logic ed, input logic [3:0] ev, input logic [63:0] eo);
        vec_t v;
        v.start = st; v.wr_en = we; v.wr_lane = ln; v.wr_addr = ad; v.wr_data = dt;
        v.exp_busy = eb; v.exp_done = ed; v.exp_valid = ev; v.exp_out = eo;
        vecs.push_back(v);
    endtask

    // One full stream; optional stray write / start during STREAM and start in DONE.
    task automatic push_stream(input int wr_step, input int st_step, input logic st_in_done);
        push_row(1'b1, 1'b0, 2'd0, 2'd0, 16'd0, 1'b1, 1'b0, 4'b0000, 64'd0);
        for (int t = 0; t < 7; t++) begin
            push_row(t == st_step, t == wr_step, 2'd2, 2'd1, 16'hBEEF,
                     1'b1, t == 6, model_valid(t), model_out(t));
        end
        push_row(st_in_done, 1'b0, 2'd0, 2'd0, 16'd0, 1'b0, 1'b0, 4'b0000, 64'd0);
        push_row(1'b0, 1'b0, 2'd0, 2'd0, 16'd0, 1'b0, 1'b0, 4'b0000, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] vpat [7];
        vpat = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
        reset = 1'b1; wr_en = 1'b0; start = 1'b0; wr_lane = 2'd0; wr_addr = 2'd0; wr_data = 16'd0;
        fa_wr_en = 1'b0; fb_wr_en = 1'b0; pe_start = 1'b0; pe_clr = 1'b1;
        f_lane = 2'd0; f_addr = 2'd0; fa_data = 16'd0; fb_data = 16'd0;
        for (int i = 0; i < 4; i++) for (int k = 0; k < 4; k++) mdl[i][k] = 16'd0;

        repeat (2) @(posedge clk);
        #1;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset lane_out", lane_out, 64'd0);
        check("reset lane_valid", 64'(lane_valid), 64'd0);
        reset = 1'b0;

        // Tile load buf[i][k] = 10*i+k+1, clean stream, stray write/starts, replay.
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 4; k++) begin
                push_row(1'b0, 1'b1, 2'(i), 2'(k), 16'(10*i + k + 1), 1'b0, 1'b0, 4'b0000, 64'd0);
                mdl[i][k] = 16'(10*i + k + 1);
            end
        end
        push_stream(-1, -1, 1'b0);
        push_stream(1, 3, 1'b1);
        push_stream(-1, -1, 1'b0);

        for (int r = 0; r < vecs.size(); r++) begin
            start = vecs[r].start; wr_en = vecs[r].wr_en; wr_lane = vecs[r].wr_lane;
            wr_addr = vecs[r].wr_addr; wr_data = vecs[r].wr_data;
            @(posedge clk);
            #1;
            check($sformatf("row%0d busy", r), 64'(busy), 64'(vecs[r].exp_busy));
            check($sformatf("row%0d done", r), 64'(done), 64'(vecs[r].exp_done));
            check($sformatf("row%0d lane_valid", r), 64'(lane_valid), 64'(vecs[r].exp_valid));
            check($sformatf("row%0d lane_out", r), lane_out, vecs[r].exp_out);
        end
        start = 1'b0; wr_en = 1'b0;

        // Reset abort at step 3.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("step3 lane_out", lane_out, {16'd31, 16'd22, 16'd13, 16'd4});
        check("step3 lane_valid", 64'(lane_valid), 64'(4'b1111));
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort lane_out", lane_out, 64'd0);
        check("abort lane_valid", 64'(lane_valid), 64'd0);
        check("abort busy", 64'(busy), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("after abort idle busy", 64'(busy), 64'd0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int t = 0; t < 7; t++) begin
            @(posedge clk); #1;
            check($sformatf("cleared step%0d lane_out", t), lane_out, 64'd0);
            check($sformatf("cleared step%0d lane_valid", t), 64'(lane_valid), 64'(vpat[t]));
            check($sformatf("cleared step%0d done", t), 64'(done), 64'(t == 6));
        end
        @(posedge clk); #1;
        check("cleared end busy", 64'(busy), 64'd0);

        // Write and start on the same edge.
        wr_en = 1'b1; wr_lane = 2'd0; wr_addr = 2'd0; wr_data = 16'h00AA; start = 1'b1;
        @(posedge clk); #1;
        wr_en = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        check("collide step0 lane_out", lane_out, 64'h0000_0000_0000_00AA);
        check("collide step0 lane_valid", 64'(lane_valid), 64'(4'b0001));
        repeat (8) @(posedge clk);
        #1;
        check("collide end busy", 64'(busy), 64'd0);

        // Identity A times known B through two feeders and the PE array.
        for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) bmat[i][j] = 16'(7*i + 3*j + 2);
        fa_wr_en = 1'b1; fb_wr_en = 1'b1;
        for (int l = 0; l < 4; l++) begin
            for (int k = 0; k < 4; k++) begin
                f_lane = 2'(l); f_addr = 2'(k);
                fa_data = (l == k) ? 16'd1 : 16'd0;
                fb_data = bmat[k][l];
                @(posedge clk); #1;
            end
        end
        fa_wr_en = 1'b0; fb_wr_en = 1'b0;
        pe_clr = 1'b0; pe_start = 1'b1;
        @(posedge clk); #1;
        pe_start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                check($sformatf("pe c[%0d][%0d]", i, j), 64'(acc[i][j]), 64'(bmat[i][j]));
            end
        end
        check("pe feeders idle", {58'd0, fa_busy, fb_busy, fa_done, fb_done, 2'b00}, 64'd0);
        check("pe feeders valid", {56'd0, fa_valid, fb_valid}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
